// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: one registered one-hot grant, each new holder keeps the
// resource for up to its programmed weight (0 counts as 1) in consecutive cycles.
// Optional feature: define WRR_ARB_LOCK_EN to add a per-agent lock input that suspends
// quantum expiry while the holder's lock bit is high.
module wrr_arbiter #(
  parameter int unsigned N  = 8,
  parameter int unsigned WW = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
`ifdef WRR_ARB_LOCK_EN
  input  logic [N-1:0]    lock,
`endif
  output logic [N-1:0]    gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            busy
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] id_q, id_d;
  logic [N-1:0]  gnt_q, gnt_d;

  logic          win_vld;
  logic [IW-1:0] win_id;
  logic [IW-1:0] cand;
  logic [WW-1:0] win_weight;
  logic          lock_h;
  logic          start_grant;

`ifdef WRR_ARB_LOCK_EN
  assign lock_h = lock[id_q];
`else
  assign lock_h = 1'b0;
`endif

  // Rotating priority search: first set req bit starting at last_q+1, wrapping through 0.
  // A sole requester that is also the holder is found last, giving a fresh quantum.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(last_q) + i) % N);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  assign win_weight = weight[win_id*WW +: WW];

  // Next-state: keep, count down, hand over, or fall idle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    id_d        = id_q;
    gnt_d       = gnt_q;
    start_grant = 1'b0;

    case (state_q)
      StIdle: begin
        if (win_vld) start_grant = 1'b1;
      end
      StGrant: begin
        if (!req[id_q]) begin
          if (win_vld) begin
            start_grant = 1'b1;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - WW'(1);
        end else if (!lock_h) begin
          // Quantum used up; holder's own req guarantees a winner exists.
          start_grant = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase

    if (start_grant) begin
      state_d        = StGrant;
      gnt_d          = '0;
      gnt_d[win_id]  = 1'b1;
      id_d           = win_id;
      last_d         = win_id;
      cnt_d          = (win_weight == '0) ? '0 : win_weight - WW'(1);
    end
  end

  // State registers; last_q resets to N-1 so agent 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= IW'(N - 1);
      id_q    <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = id_q;
  assign busy   = |gnt_q;

endmodule
